// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle 32-bit core: opcodes, special
// instruction words and the fetch-stage state encoding.
package cpu_pkg;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_J     = 6'b000010;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_ANDI  = 6'b001100;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_HALT  = 6'b111111;

    localparam logic [31:0] HALT_WORD = {OPC_HALT, 26'h0};
    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

    typedef enum logic {
        FS_RUN  = 1'b0,
        FS_HALT = 1'b1
    } fetch_state_e;

    function automatic logic is_halt_word(input logic [31:0] word);
        return word == HALT_WORD;
    endfunction

endpackage

// File: rtl/pc_next_logic.sv
// Next-PC selection for the fetch stage: hold, jump, taken branch or
// sequential, in that priority order.
module pc_next_logic (
    input  logic [31:0] pc_plus4,
    input  logic [25:0] instr,
    input  logic        jump,
    input  logic        branch,
    input  logic        zero,
    input  logic        hold,
    output logic [31:0] next_pc
);

    logic [31:0] br_tgt;
    logic [31:0] j_tgt;

    assign br_tgt = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00};
    assign j_tgt  = {pc_plus4[31:28], instr[25:0], 2'b00};

    // NOTE: next_pc gets its default before any branch of the if-chain so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        next_pc = pc_plus4;
        if (hold) begin
            // the current PC is not a port here; it is recovered from pc_plus4
            next_pc = pc_plus4 - 32'd4;
        end else if (jump) begin
            next_pc = j_tgt;
        end else if (branch && zero) begin
            next_pc = br_tgt;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC register, combinational instruction ROM, run/halt FSM
// and retired-instruction counter.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = 64,
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter              INIT_FILE  = "imem.hex"
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        jump,
    input  logic        branch,
    input  logic        zero,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic        halted,
    output logic        fault,
    output logic [31:0] instr_count
);

    localparam int unsigned AW = $clog2(IMEM_DEPTH);

    // NOTE: the ROM has no reset; its contents are preloaded, never cleared.
    logic [31:0] imem [IMEM_DEPTH];

    fetch_state_e state, state_next;
    logic         fault_next;
    logic         retire;
    logic         hold;
    logic         out_of_range;
    logic [31:0]  rom_word;
    logic [31:0]  next_pc;

    assign rom_word     = imem[pc[AW+1:2]];
    assign out_of_range = (pc[31:AW+2] != '0);
    assign pc_plus4     = pc + 32'd4;
    assign opcode       = instr[31:26];
    assign halted       = (state == FS_HALT);

    // A fetch outside the ROM must not alias onto a low word; it faults instead.
    always_comb begin
        state_next = state;
        fault_next = fault;
        retire     = 1'b0;
        hold       = 1'b1;
        instr      = NOP_WORD;
        if (state == FS_RUN) begin
            if (!out_of_range) begin
                instr = rom_word;
            end
            if (!stall) begin
                if (out_of_range) begin
                    state_next = FS_HALT;
                    fault_next = 1'b1;
                end else begin
                    retire = 1'b1;
                    if (is_halt_word(rom_word)) begin
                        state_next = FS_HALT;
                    end else begin
                        hold = 1'b0;
                    end
                end
            end
        end
    end

    pc_next_logic u_pc_next_logic (
        .pc_plus4 (pc_plus4),
        .instr    (instr[25:0]),
        .jump     (jump),
        .branch   (branch),
        .zero     (zero),
        .hold     (hold),
        .next_pc  (next_pc)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            state       <= FS_RUN;
            fault       <= 1'b0;
            instr_count <= 32'd0;
        end else begin
            pc    <= next_pc;
            state <= state_next;
            fault <= fault_next;
            if (retire) begin
                instr_count <= instr_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: reset, sequencing, branch/jump targets,
// stall, halt and out-of-range fault on a shallow ROM.
module tb_instr_fetch;
    import cpu_pkg::*;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        jump;
    logic        branch;
    logic        zero;

    logic [31:0] pc, pc_plus4, instr, instr_count;
    logic [5:0]  opcode;
    logic        halted, fault;

    logic [31:0] s_pc, s_pc_plus4, s_instr, s_instr_count;
    logic [5:0]  s_opcode;
    logic        s_halted, s_fault;

    int n_compared;
    int n_mismatched;

    instr_fetch #(.IMEM_DEPTH(64), .RESET_PC(32'h0), .INIT_FILE("")) dut (
        .clk(clk), .reset(reset), .stall(stall), .jump(jump), .branch(branch), .zero(zero),
        .pc(pc), .pc_plus4(pc_plus4), .instr(instr), .opcode(opcode),
        .halted(halted), .fault(fault), .instr_count(instr_count)
    );

    instr_fetch #(.IMEM_DEPTH(4), .RESET_PC(32'h0), .INIT_FILE("")) dut_small (
        .clk(clk), .reset(reset), .stall(stall), .jump(jump), .branch(branch), .zero(zero),
        .pc(s_pc), .pc_plus4(s_pc_plus4), .instr(s_instr), .opcode(s_opcode),
        .halted(s_halted), .fault(s_fault), .instr_count(s_instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] addi_word(input int i);
        logic [31:0] v;
        v = i;
        return {OPC_ADDI, 5'd0, 5'd1, v[15:0]};
    endfunction

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        stall  = 1'b0;
        jump   = 1'b0;
        branch = 1'b0;
        zero   = 1'b0;
        reset  = 1'b1;
        #2;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Straight-line ADDI image in the main ROM; everything past it is NOP.
    task automatic load_seq();
        for (int i = 0; i < 64; i++) dut.imem[i] = (i < 16) ? addi_word(i) : NOP_WORD;
    endtask

    task automatic test_reset();
        load_seq();
        reset = 1'b1;
        step(2);
        n_compared++;
        if (pc !== 32'h0) begin n_mismatched++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
        n_compared++;
        if (pc_plus4 !== 32'h4) begin n_mismatched++; $display("FAIL reset_pc_plus4: got %h want %h", pc_plus4, 32'h4); end
        n_compared++;
        if ({halted, fault} !== 2'b00) begin n_mismatched++; $display("FAIL reset_flags: got %b want 00", {halted, fault}); end
        n_compared++;
        if (instr_count !== 32'd0) begin n_mismatched++; $display("FAIL reset_count: got %0d want 0", instr_count); end
        n_compared++;
        if (instr !== addi_word(0)) begin n_mismatched++; $display("FAIL reset_instr: got %h want %h", instr, addi_word(0)); end
        do_reset();
        step(8);
        n_compared++;
        if (pc !== 32'h20) begin n_mismatched++; $display("FAIL run_to_20_pc: got %h want %h", pc, 32'h20); end
        #2;
        reset = 1'b1;
        #1;
        n_compared++;
        if (pc !== 32'h0) begin n_mismatched++; $display("FAIL async_reset_pc: got %h want %h", pc, 32'h0); end
        n_compared++;
        if (instr_count !== 32'd0) begin n_mismatched++; $display("FAIL async_reset_count: got %0d want 0", instr_count); end
        n_compared++;
        if (halted !== 1'b0) begin n_mismatched++; $display("FAIL async_reset_halted: got %b want 0", halted); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        load_seq();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            exp_pc = 32'(i * 4);
            n_compared++;
            if (pc !== exp_pc || instr !== addi_word(i)) begin
                n_mismatched++;
                $display("FAIL seq_pc_%0d: got pc %h instr %h want pc %h instr %h", i, pc, instr, exp_pc, addi_word(i));
            end
            step(1);
        end
        n_compared++;
        if (instr_count !== 32'd5) begin n_mismatched++; $display("FAIL seq_count: got %0d want 5", instr_count); end
        n_compared++;
        if (opcode !== OPC_ADDI) begin n_mismatched++; $display("FAIL seq_opcode: got %b want %b", opcode, OPC_ADDI); end
    endtask

    task automatic test_branch();
        load_seq();
        dut.imem[2] = {OPC_BEQ, 5'd1, 5'd2, 16'hFFFE};
        do_reset();
        step(2);
        branch = 1'b1;
        zero   = 1'b1;
        n_compared++;
        if (opcode !== OPC_BEQ) begin n_mismatched++; $display("FAIL beq_opcode: got %b want %b", opcode, OPC_BEQ); end
        step(1);
        n_compared++;
        if (pc !== 32'h4) begin n_mismatched++; $display("FAIL beq_taken_pc: got %h want %h", pc, 32'h4); end
        branch = 1'b0;
        step(1);
        branch = 1'b1;
        zero   = 1'b0;
        step(1);
        n_compared++;
        if (pc !== 32'hC) begin n_mismatched++; $display("FAIL beq_not_taken_pc: got %h want %h", pc, 32'hC); end
        n_compared++;
        if (instr_count !== 32'd5) begin n_mismatched++; $display("FAIL beq_count: got %0d want 5", instr_count); end
    endtask

    task automatic test_jump();
        load_seq();
        dut.imem[4] = {OPC_J, 26'h3};
        do_reset();
        step(4);
        jump   = 1'b1;
        branch = 1'b1;
        zero   = 1'b1;
        step(1);
        n_compared++;
        if (pc !== 32'hC) begin n_mismatched++; $display("FAIL jump_wins_pc: got %h want %h", pc, 32'hC); end
    endtask

    task automatic test_stall();
        load_seq();
        do_reset();
        step(2);
        stall = 1'b1;
        step(3);
        n_compared++;
        if (pc !== 32'h8 || instr_count !== 32'd2) begin
            n_mismatched++;
            $display("FAIL stall_hold: got pc %h count %0d want pc %h count 2", pc, instr_count, 32'h8);
        end
        n_compared++;
        if (instr !== addi_word(2)) begin n_mismatched++; $display("FAIL stall_instr: got %h want %h", instr, addi_word(2)); end
        stall = 1'b0;
        step(1);
        n_compared++;
        if (pc !== 32'hC || instr_count !== 32'd3) begin
            n_mismatched++;
            $display("FAIL stall_release: got pc %h count %0d want pc %h count 3", pc, instr_count, 32'hC);
        end
    endtask

    task automatic test_halt();
        load_seq();
        dut.imem[5] = HALT_WORD;
        do_reset();
        step(5);
        n_compared++;
        if (instr !== HALT_WORD || halted !== 1'b0) begin
            n_mismatched++;
            $display("FAIL halt_fetch: got instr %h halted %b want %h 0", instr, halted, HALT_WORD);
        end
        stall = 1'b1;
        step(1);
        n_compared++;
        if (halted !== 1'b0 || pc !== 32'h14) begin
            n_mismatched++;
            $display("FAIL halt_stalled: got halted %b pc %h want 0 %h", halted, pc, 32'h14);
        end
        stall = 1'b0;
        step(1);
        n_compared++;
        if (halted !== 1'b1 || fault !== 1'b0) begin
            n_mismatched++;
            $display("FAIL halt_flags: got halted %b fault %b want 1 0", halted, fault);
        end
        n_compared++;
        if (pc !== 32'h14 || instr !== 32'h0 || opcode !== 6'h0) begin
            n_mismatched++;
            $display("FAIL halt_outputs: got pc %h instr %h opcode %h want %h 0 0", pc, instr, opcode, 32'h14);
        end
        n_compared++;
        if (instr_count !== 32'd6) begin n_mismatched++; $display("FAIL halt_count: got %0d want 6", instr_count); end
        for (int i = 0; i < 4; i++) begin
            stall = i[0];
            jump  = ~i[0];
            step(1);
        end
        n_compared++;
        if (pc !== 32'h14 || instr_count !== 32'd6 || halted !== 1'b1) begin
            n_mismatched++;
            $display("FAIL halt_frozen: got pc %h count %0d halted %b want %h 6 1", pc, instr_count, halted, 32'h14);
        end
    endtask

    task automatic test_out_of_range();
        for (int i = 0; i < 4; i++) dut_small.imem[i] = addi_word(i + 1);
        do_reset();
        step(4);
        n_compared++;
        if (s_pc !== 32'h10 || s_instr !== NOP_WORD || s_halted !== 1'b0) begin
            n_mismatched++;
            $display("FAIL oor_fetch: got pc %h instr %h halted %b want %h 0 0", s_pc, s_instr, s_halted, 32'h10);
        end
        step(1);
        n_compared++;
        if (s_halted !== 1'b1 || s_fault !== 1'b1) begin
            n_mismatched++;
            $display("FAIL oor_flags: got halted %b fault %b want 1 1", s_halted, s_fault);
        end
        n_compared++;
        if (s_instr_count !== 32'd4 || s_pc !== 32'h10) begin
            n_mismatched++;
            $display("FAIL oor_state: got count %0d pc %h want 4 %h", s_instr_count, s_pc, 32'h10);
        end
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        reset  = 1'b1;
        stall  = 1'b0;
        jump   = 1'b0;
        branch = 1'b0;
        zero   = 1'b0;
        for (int i = 0; i < 4; i++) dut_small.imem[i] = NOP_WORD;
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_stall();
        test_halt();
        test_out_of_range();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
